rv_cluster_sched: RTL and testbench

Parametrised round-robin hart scheduler for the RV cluster. It owns the hart-select register, the per-hart busy gating and the per-hart page-fault routing for N_HARTS cores that share one memory port and one MMU. It adds a configurable time slice (QUANTUM), a one-cycle switch bubble, and optional skipping of harts that have no work. It sits between the cores and the shared memory controller/MMU inside the cluster top.

---
 rtl/rv_cluster_sched.sv | 141 ++++++++++++++
 tb/tb_rv_cluster_sched.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rv_cluster_sched.sv
// Round-robin hart scheduler: hart-select register, per-hart busy gating and page-fault routing.
// Optional macro RVC_SCHED_SKIP_IDLE_EN: rotation skips harts whose w_req is low.
module rv_cluster_sched #(
  parameter int unsigned N_HARTS = 2,
  parameter int unsigned QUANTUM = 1
) (
  input  logic                              CLK,
  input  logic                              RST_X,
  input  logic [N_HARTS-1:0]                w_req,
  input  logic                              w_switch_ok,
  input  logic                              w_mode_is_cpu,
  input  logic                              w_next_mode_is_mc,
  input  logic                              w_busy,
  input  logic [31:0]                       w_mmu_pagefault,
  output logic [((N_HARTS>1) ? $clog2(N_HARTS) : 1)-1:0] r_hart_sel,
  output logic [N_HARTS-1:0]                w_sel_onehot,
  output logic [N_HARTS-1:0]                w_core_busy,
  output logic [32*N_HARTS-1:0]             w_core_pagefault,
  output logic                              r_switch,
  output logic [7:0]                        r_slice_cnt
);

  localparam int unsigned SEL_W = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;
  localparam int unsigned IDX_W = SEL_W + 1;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_HARTS - 1);
  localparam logic [7:0]       CNT_LAST = 8'(QUANTUM - 1);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SWITCH = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [SEL_W-1:0] hart_nxt;
  logic [7:0]       cnt_nxt;
  logic             switch_nxt;
  logic             ev;
  logic [N_HARTS-1:0] owner;

  assign ev = w_switch_ok & w_mode_is_cpu & ~w_next_mode_is_mc;

`ifdef RVC_SCHED_SKIP_IDLE_EN
  logic [IDX_W-1:0] skip_idx;
  logic             skip_found;

  // First requesting hart after the current one; current hart keeps the port if none.
  always_comb begin
    hart_nxt   = r_hart_sel;
    skip_found = 1'b0;
    skip_idx   = '0;
    for (int unsigned k = 1; k < N_HARTS; k++) begin
      skip_idx = IDX_W'(r_hart_sel) + IDX_W'(k);
      if (skip_idx >= IDX_W'(N_HARTS)) begin
        skip_idx = skip_idx - IDX_W'(N_HARTS);
      end
      if (!skip_found && w_req[skip_idx[SEL_W-1:0]]) begin
        hart_nxt   = skip_idx[SEL_W-1:0];
        skip_found = 1'b1;
      end
    end
  end
`else
  logic unused_req;
  assign unused_req = ^w_req;

  // Strict rotation; with a single hart this always yields the current hart.
  always_comb begin
    hart_nxt = r_hart_sel;
    if (r_hart_sel == SEL_LAST) begin
      hart_nxt = '0;
    end else begin
      hart_nxt = r_hart_sel + SEL_W'(1);
    end
  end
`endif

  // Slice accounting and RUN/SWITCH sequencing.
  always_comb begin
    state_nxt  = state;
    sel_nxt    = r_hart_sel;
    cnt_nxt    = r_slice_cnt;
    switch_nxt = 1'b0;
    case (state)
      ST_RUN: begin
        if (ev) begin
          if (r_slice_cnt == CNT_LAST) begin
            cnt_nxt = 8'd0;
            if (hart_nxt != r_hart_sel) begin
              sel_nxt    = hart_nxt;
              switch_nxt = 1'b1;
              state_nxt  = ST_SWITCH;
            end
          end else begin
            cnt_nxt = r_slice_cnt + 8'd1;
          end
        end
      end
      ST_SWITCH: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state       <= ST_RUN;
      r_hart_sel  <= '0;
      r_slice_cnt <= 8'd0;
      r_switch    <= 1'b0;
    end else begin
      state       <= state_nxt;
      r_hart_sel  <= sel_nxt;
      r_slice_cnt <= cnt_nxt;
      r_switch    <= switch_nxt;
    end
  end

  // Owner decode is blanked for the whole switch bubble.
  always_comb begin
    owner = '0;
    for (int unsigned g = 0; g < N_HARTS; g++) begin
      owner[g] = (state == ST_RUN) && (r_hart_sel == SEL_W'(g));
    end
  end

  assign w_sel_onehot = owner;

  always_comb begin
    w_core_busy      = '1;
    w_core_pagefault = '1;
    for (int unsigned g = 0; g < N_HARTS; g++) begin
      if (owner[g]) begin
        w_core_busy[g]             = w_busy;
        w_core_pagefault[32*g +: 32] = w_mmu_pagefault;
      end
    end
  end

endmodule

// File: tb/tb_rv_cluster_sched.sv
// Scoreboard bench for rv_cluster_sched: instance A (4 harts, quantum 1), instance B (2 harts, quantum 3).
module tb_rv_cluster_sched;

  typedef struct {
    string       tag;
    logic [3:0]  sel;
    logic        sw;
    logic [7:0]  cnt;
    logic [3:0]  oh;
    logic [3:0]  busy;
    int          pfh;
    logic [31:0] pf;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_X;
  logic [3:0]  req;
  logic        sok_a, sok_b, cpu, nmc, busy;
  logic [31:0] pf;

  logic [1:0]   a_sel;
  logic [3:0]   a_oh, a_busy;
  logic [127:0] a_pf;
  logic         a_sw;
  logic [7:0]   a_cnt;

  logic [0:0]   b_sel;
  logic [1:0]   b_oh, b_busy;
  logic [63:0]  b_pf;
  logic         b_sw;
  logic [7:0]   b_cnt;

  exp_t qa[$];
  exp_t qb[$];
  int   n_vec = 0;
  int   n_err = 0;

  int         nxt_tab[4] = '{1, 2, 3, 0};
  logic [3:0] oh_tab[4]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] bz_tab[4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always #5 CLK = ~CLK;

  rv_cluster_sched #(.N_HARTS(4), .QUANTUM(1)) dut_a (
    .CLK(CLK), .RST_X(RST_X), .w_req(req), .w_switch_ok(sok_a),
    .w_mode_is_cpu(cpu), .w_next_mode_is_mc(nmc), .w_busy(busy),
    .w_mmu_pagefault(pf), .r_hart_sel(a_sel), .w_sel_onehot(a_oh),
    .w_core_busy(a_busy), .w_core_pagefault(a_pf), .r_switch(a_sw),
    .r_slice_cnt(a_cnt)
  );

  rv_cluster_sched #(.N_HARTS(2), .QUANTUM(3)) dut_b (
    .CLK(CLK), .RST_X(RST_X), .w_req(req[1:0]), .w_switch_ok(sok_b),
    .w_mode_is_cpu(cpu), .w_next_mode_is_mc(nmc), .w_busy(busy),
    .w_mmu_pagefault(pf), .r_hart_sel(b_sel), .w_sel_onehot(b_oh),
    .w_core_busy(b_busy), .w_core_pagefault(b_pf), .r_switch(b_sw),
    .r_slice_cnt(b_cnt)
  );

  function automatic exp_t mk(string tag, logic [3:0] sel, logic sw, logic [7:0] cnt,
                              logic [3:0] oh, logic [3:0] bz, int pfh);
    exp_t e;
    e.tag = tag; e.sel = sel; e.sw = sw; e.cnt = cnt;
    e.oh = oh; e.busy = bz; e.pfh = pfh; e.pf = pf;
    return e;
  endfunction

  function automatic void push_a(string tag, logic [3:0] sel, logic sw, logic [7:0] cnt,
                                 logic [3:0] oh, logic [3:0] bz, int pfh);
    qa.push_back(mk(tag, sel, sw, cnt, oh, bz, pfh));
  endfunction

  function automatic void push_b(string tag, logic [3:0] sel, logic sw, logic [7:0] cnt,
                                 logic [3:0] oh, logic [3:0] bz, int pfh);
    qb.push_back(mk(tag, sel, sw, cnt, oh, bz, pfh));
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitors: pop one expectation per cycle and compare mid-cycle.
  always @(negedge CLK) begin
    exp_t         e;
    logic [127:0] pfe;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      for (int g = 0; g < 4; g++) pfe[32*g +: 32] = (g == e.pfh) ? e.pf : 32'hFFFF_FFFF;
      n_vec++;
      if (a_sel !== e.sel[1:0] || a_sw !== e.sw || a_cnt !== e.cnt ||
          a_oh !== e.oh || a_busy !== e.busy || a_pf !== pfe) begin
        n_err++;
        $display("FAIL A:%s got sel=%0d sw=%b cnt=%0d oh=%b busy=%b pf=%h want sel=%0d sw=%b cnt=%0d oh=%b busy=%b pf=%h",
                 e.tag, a_sel, a_sw, a_cnt, a_oh, a_busy, a_pf,
                 e.sel[1:0], e.sw, e.cnt, e.oh, e.busy, pfe);
      end
    end
  end

  always @(negedge CLK) begin
    exp_t        e;
    logic [63:0] pfe;
    if (qb.size() > 0) begin
      e = qb.pop_front();
      for (int g = 0; g < 2; g++) pfe[32*g +: 32] = (g == e.pfh) ? e.pf : 32'hFFFF_FFFF;
      n_vec++;
      if (b_sel !== e.sel[0:0] || b_sw !== e.sw || b_cnt !== e.cnt ||
          b_oh !== e.oh[1:0] || b_busy !== e.busy[1:0] || b_pf !== pfe) begin
        n_err++;
        $display("FAIL B:%s got sel=%0d sw=%b cnt=%0d oh=%b busy=%b pf=%h want sel=%0d sw=%b cnt=%0d oh=%b busy=%b pf=%h",
                 e.tag, b_sel, b_sw, b_cnt, b_oh, b_busy, b_pf,
                 e.sel[0:0], e.sw, e.cnt, e.oh[1:0], e.busy[1:0], pfe);
      end
    end
  end

  initial begin
    RST_X = 1'b0; req = 4'b1111; sok_a = 1'b0; sok_b = 1'b0;
    cpu = 1'b1; nmc = 1'b0; busy = 1'b0; pf = 32'h0000_000D;

    tick(); push_a("rst", 0, 0, 0, 4'b0001, 4'b1110, 0);
            push_b("rst", 0, 0, 0, 4'b0001, 4'b0010, 0);
    tick(); RST_X = 1'b1; push_a("rst_rel", 0, 0, 0, 4'b0001, 4'b1110, 0);

    // Strict rotation 0,1,2,3,0 with one event every five cycles.
    for (int k = 0; k < 4; k++) begin
      tick(); sok_a = 1'b1; push_a("rot_ev", 4'(k), 0, 0, oh_tab[k], bz_tab[k], k);
      tick(); sok_a = 1'b0; push_a("rot_sw", 4'(nxt_tab[k]), 1, 0, 4'b0000, 4'b1111, -1);
      for (int j = 0; j < 3; j++) begin
        tick(); push_a("rot_run", 4'(nxt_tab[k]), 0, 0, oh_tab[nxt_tab[k]], bz_tab[nxt_tab[k]], nxt_tab[k]);
      end
    end

    // Busy mirroring and page-fault routing on hart 1.
    tick(); sok_a = 1'b1; push_a("ev01", 0, 0, 0, 4'b0001, 4'b1110, 0);
    tick(); sok_a = 1'b0; push_a("sw01", 1, 1, 0, 4'b0000, 4'b1111, -1);
    tick(); busy = 1'b1; push_a("busy_hi", 1, 0, 0, 4'b0010, 4'b1111, 1);
    tick(); busy = 1'b0; push_a("busy_lo", 1, 0, 0, 4'b0010, 4'b1101, 1);
    tick(); busy = 1'b1; pf = 32'h0000_0003; push_a("busy_hi2", 1, 0, 0, 4'b0010, 4'b1111, 1);
    tick(); busy = 1'b0; pf = 32'h0000_000D; push_a("busy_lo2", 1, 0, 0, 4'b0010, 4'b1101, 1);

    // Blocked events: mode leaving CPU, or not in CPU mode.
    tick(); sok_a = 1'b1; nmc = 1'b1; push_a("nmc_ev", 1, 0, 0, 4'b0010, 4'b1101, 1);
    tick(); nmc = 1'b0; cpu = 1'b0;   push_a("cpu0_ev", 1, 0, 0, 4'b0010, 4'b1101, 1);
    tick(); sok_a = 1'b0; cpu = 1'b1; push_a("blk_hold", 1, 0, 0, 4'b0010, 4'b1101, 1);

    // Reset asserted in the SWITCH cycle into hart 2.
    tick(); sok_a = 1'b1; push_a("ev12", 1, 0, 0, 4'b0010, 4'b1101, 1);
    tick(); sok_a = 1'b0; RST_X = 1'b0; push_a("sw12", 2, 1, 0, 4'b0000, 4'b1111, -1);
    tick(); RST_X = 1'b1; push_a("rst_sw", 0, 0, 0, 4'b0001, 4'b1110, 0);

    // Event held through the SWITCH cycle must not advance twice.
    tick(); sok_a = 1'b1; push_a("ev_ign", 0, 0, 0, 4'b0001, 4'b1110, 0);
    tick(); push_a("sw_ev", 1, 1, 0, 4'b0000, 4'b1111, -1);
    tick(); sok_a = 1'b0; push_a("sw_ign", 1, 0, 0, 4'b0010, 4'b1101, 1);

`ifdef RVC_SCHED_SKIP_IDLE_EN
    tick(); req = 4'b1001; sok_a = 1'b1; push_a("ev_skip", 1, 0, 0, 4'b0010, 4'b1101, 1);
    tick(); sok_a = 1'b0; push_a("sw_skip", 3, 1, 0, 4'b0000, 4'b1111, -1);
    tick(); push_a("run3", 3, 0, 0, 4'b1000, 4'b0111, 3);
    tick(); sok_a = 1'b1; push_a("ev_skip2", 3, 0, 0, 4'b1000, 4'b0111, 3);
    tick(); sok_a = 1'b0; push_a("sw_skip2", 0, 1, 0, 4'b0000, 4'b1111, -1);
    tick(); push_a("run0", 0, 0, 0, 4'b0001, 4'b1110, 0);
    tick(); req = 4'b0001; sok_a = 1'b1; push_a("ev_self", 0, 0, 0, 4'b0001, 4'b1110, 0);
    tick(); sok_a = 1'b0; push_a("no_sw", 0, 0, 0, 4'b0001, 4'b1110, 0);
`else
    tick(); req = 4'b0001; sok_a = 1'b1; push_a("ev_strict", 1, 0, 0, 4'b0010, 4'b1101, 1);
    tick(); sok_a = 1'b0; push_a("sw_strict", 2, 1, 0, 4'b0000, 4'b1111, -1);
    tick(); push_a("run2", 2, 0, 0, 4'b0100, 4'b1011, 2);
`endif

    // Instance B: three events per slice before rotating to hart 1.
    tick(); req = 4'b1111; sok_b = 1'b1; push_b("b_ev1", 0, 0, 0, 4'b0001, 4'b0010, 0);
    tick(); sok_b = 1'b0; push_b("b_cnt1", 0, 0, 1, 4'b0001, 4'b0010, 0);
    tick(); sok_b = 1'b1; nmc = 1'b1; push_b("b_nmc", 0, 0, 1, 4'b0001, 4'b0010, 0);
    tick(); nmc = 1'b0; push_b("b_hold", 0, 0, 1, 4'b0001, 4'b0010, 0);
    tick(); sok_b = 1'b0; push_b("b_cnt2", 0, 0, 2, 4'b0001, 4'b0010, 0);
    tick(); push_b("b_idle", 0, 0, 2, 4'b0001, 4'b0010, 0);
    tick(); sok_b = 1'b1; push_b("b_ev3", 0, 0, 2, 4'b0001, 4'b0010, 0);
    tick(); sok_b = 1'b0; push_b("b_sw", 1, 1, 0, 4'b0000, 4'b0011, -1);
    tick(); push_b("b_run1", 1, 0, 0, 4'b0010, 4'b0001, 1);
    tick(); busy = 1'b1; push_b("b_busy", 1, 0, 0, 4'b0010, 4'b0011, 1);
    tick(); busy = 1'b0; push_b("b_idle2", 1, 0, 0, 4'b0010, 4'b0001, 1);

    repeat (2) @(negedge CLK);
    #1;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d/%0d expectations left, want 0/0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
